// File: rtl/serial_compare_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// State encodings and the bit-index width derivation.
package serial_compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index must be at least one bit wide even for the narrowest operand.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_cell.sv
// One bit-pair decision: whether the bits differ and, if so, whether a wins.
// invert flips the decision for the sign bit of two's-complement operands.
module serial_compare_cell
    import serial_compare_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic invert,
    output logic differ,
    output logic a_greater
);

    assign differ    = a_bit ^ b_bit;
    assign a_greater = differ & (a_bit ^ invert);

endmodule

// File: rtl/serial_compare.sv
// Bit-serial comparator: examines one latched bit pair per cycle, MSB first,
// and reports a registered gt/eq/lt result with a one-cycle done pulse.
module serial_compare
    import serial_compare_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               signed_q;
    logic [IDX_W-1:0]   idx_q;
    logic               found_q, first_gt_q;
    logic               gt_q, eq_q, lt_q;

    logic               differ, a_greater, invert;
    logic               load, finish, hit;
    logic               res_gt, res_eq, res_lt;

    assign invert = signed_q & (idx_q == IDX_TOP);

    serial_compare_cell u_cell (
        .a_bit     (a_q[idx_q]),
        .b_bit     (b_q[idx_q]),
        .invert    (invert),
        .differ    (differ),
        .a_greater (a_greater)
    );

    // With EARLY_EXIT=0 the first differing bit is remembered in found_q/first_gt_q.
    assign hit = differ & ~found_q;

    always_comb begin
        res_gt = 1'b0;
        res_eq = 1'b0;
        res_lt = 1'b0;
        if (found_q) begin
            res_gt = first_gt_q;
            res_lt = ~first_gt_q;
        end else if (differ) begin
            res_gt = a_greater;
            res_lt = ~a_greater;
        end else begin
            res_eq = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((hit && (EARLY_EXIT != 0)) || (idx_q == '0)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            idx_q      <= '0;
            found_q    <= 1'b0;
            first_gt_q <= 1'b0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q        <= a;
                b_q        <= b;
                signed_q   <= signed_mode;
                idx_q      <= IDX_TOP;
                found_q    <= 1'b0;
                first_gt_q <= 1'b0;
            end else if (state_q == RUN) begin
                if (hit) begin
                    found_q    <= 1'b1;
                    first_gt_q <= a_greater;
                end
                if (!finish) begin
                    idx_q <= idx_q - 1'b1;
                end
            end
            if (finish) begin
                gt_q <= res_gt;
                eq_q <= res_eq;
                lt_q <= res_lt;
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_serial_compare.sv
// Directed and exhaustive checks of serial_compare at WIDTH=4, with one
// instance per EARLY_EXIT setting driven from the same inputs.
module tb_serial_compare;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a_in = 4'd0;
    logic [3:0] b_in = 4'd0;
    logic       sm = 1'b0;

    logic busy1, done1, gt1, eq1, lt1;
    logic busy0, done0, gt0, eq0, lt0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_compare #(.WIDTH(4), .EARLY_EXIT(1)) dut_ee1 (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in),
        .signed_mode(sm), .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
    );

    serial_compare #(.WIDTH(4), .EARLY_EXIT(0)) dut_ee0 (
        .clk(clk), .rst(rst), .start(start), .a(a_in), .b(b_in),
        .signed_mode(sm), .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0)
    );

    // Reference: flags {gt,eq,lt} and cycles from start edge to done observation.
    function automatic void model(input logic [3:0] ma, input logic [3:0] mb, input logic msm,
                                  input bit ee, output logic [2:0] flags, output int lat);
        int ai, bi, p;
        logic [3:0] d;
        ai = (msm && ma[3]) ? int'(ma) - 16 : int'(ma);
        bi = (msm && mb[3]) ? int'(mb) - 16 : int'(mb);
        flags = (ai > bi) ? 3'b100 : ((ai == bi) ? 3'b010 : 3'b001);
        d = ma ^ mb;
        p = -1;
        for (int i = 0; i < 4; i++) if (d[i]) p = i;
        lat = (ee && p >= 0) ? (4 - p) + 1 : 5;
    endfunction

    // Pulses start, scrambles the inputs afterwards, and observes both instances.
    task automatic do_compare(input logic [3:0] ta, input logic [3:0] tb, input logic tsm,
                              output int lat1, output int nd1, output logic [2:0] f1,
                              output int lat0, output int nd0, output logic [2:0] f0);
        lat1 = -1; nd1 = 0; f1 = 3'b000;
        lat0 = -1; nd0 = 0; f0 = 3'b000;
        @(negedge clk);
        a_in = ta; b_in = tb; sm = tsm; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            a_in = ~ta; b_in = ~tb; sm = ~tsm;
            if (done1) begin
                nd1++;
                if (lat1 < 0) begin lat1 = k; f1 = {gt1, eq1, lt1}; end
            end
            if (done0) begin
                nd0++;
                if (lat0 < 0) begin lat0 = k; f0 = {gt0, eq0, lt0}; end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({busy1, done1, gt1, eq1, lt1, busy0, done0, gt0, eq0, lt0} !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 0000000000",
                     {busy1, done1, gt1, eq1, lt1, busy0, done0, gt0, eq0, lt0});
        end
        rst = 1'b0;
    endtask

    task automatic check_pair(input string name, input logic [3:0] ta, input logic [3:0] tb,
                              input logic tsm, input int xl1, input logic [2:0] xf1,
                              input int xl0, input logic [2:0] xf0);
        int l1, n1, l0, n0;
        logic [2:0] f1, f0;
        do_compare(ta, tb, tsm, l1, n1, f1, l0, n0, f0);
        tests_run++;
        if (f1 !== xf1 || l1 != xl1 || n1 != 1) begin
            tests_failed++;
            $display("FAIL %s_ee1: got flags=%b lat=%0d dones=%0d want flags=%b lat=%0d dones=1",
                     name, f1, l1, n1, xf1, xl1);
        end
        tests_run++;
        if (f0 !== xf0 || l0 != xl0 || n0 != 1) begin
            tests_failed++;
            $display("FAIL %s_ee0: got flags=%b lat=%0d dones=%0d want flags=%b lat=%0d dones=1",
                     name, f0, l0, n0, xf0, xl0);
        end
    endtask

    task automatic test_unsigned;
        check_pair("unsigned_9_5", 4'd9, 4'd5, 1'b0, 2, 3'b100, 5, 3'b100);
        check_pair("unsigned_5_9", 4'd5, 4'd9, 1'b0, 2, 3'b001, 5, 3'b001);
    endtask

    task automatic test_signed;
        check_pair("signed_m7_5", 4'b1001, 4'd5, 1'b1, 2, 3'b001, 5, 3'b001);
        check_pair("signed_m1_m2", 4'b1111, 4'b1110, 1'b1, 5, 3'b100, 5, 3'b100);
    endtask

    task automatic test_equal;
        check_pair("equal_10", 4'd10, 4'd10, 1'b0, 5, 3'b010, 5, 3'b010);
        check_pair("equal_signed_10", 4'd10, 4'd10, 1'b1, 5, 3'b010, 5, 3'b010);
    endtask

    task automatic test_start_during_run;
        logic [2:0] f1, f0;
        int l1, l0;
        l1 = -1; l0 = -1; f1 = 3'b000; f0 = 3'b000;
        @(negedge clk);
        a_in = 4'd2; b_in = 4'd3; sm = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                start = 1'b1; a_in = 4'd0; b_in = 4'd15;
            end else begin
                start = 1'b0;
            end
            if (k == 2) begin
                tests_run++;
                if ({busy1, busy0} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL run_busy: got %b want 11", {busy1, busy0});
                end
            end
            if (done1 && l1 < 0) begin l1 = k; f1 = {gt1, eq1, lt1}; end
            if (done0 && l0 < 0) begin l0 = k; f0 = {gt0, eq0, lt0}; end
        end
        tests_run++;
        if (l1 != 5 || f1 !== 3'b001 || l0 != 5 || f0 !== 3'b001) begin
            tests_failed++;
            $display("FAIL start_in_run: got lat=%0d/%0d flags=%b/%b want 5/5 001/001",
                     l1, l0, f1, f0);
        end
        tests_run++;
        if ({done1, done0, busy1, busy0, lt1, lt0} !== 6'b000011) begin
            tests_failed++;
            $display("FAIL result_hold: got %b want 000011",
                     {done1, done0, busy1, busy0, lt1, lt0});
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        a_in = 4'd9; b_in = 4'd5; sm = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) begin
                tests_run++;
                if ({done1, busy1, gt1, eq1, lt1} !== 5'b10100) begin
                    tests_failed++;
                    $display("FAIL b2b_first: got %b want 10100", {done1, busy1, gt1, eq1, lt1});
                end
                a_in = 4'd5; b_in = 4'd9; start = 1'b1;
            end
            if (k == 3) begin
                tests_run++;
                if ({done1, busy1} !== 2'b01) begin
                    tests_failed++;
                    $display("FAIL b2b_restart: got %b want 01", {done1, busy1});
                end
            end
            if (k == 4) begin
                tests_run++;
                if ({done1, gt1, eq1, lt1} !== 4'b1001) begin
                    tests_failed++;
                    $display("FAIL b2b_second: got %b want 1001", {done1, gt1, eq1, lt1});
                end
            end
            if (k == 5) begin
                tests_run++;
                if ({done0, gt0, eq0, lt0} !== 4'b1100) begin
                    tests_failed++;
                    $display("FAIL b2b_ee0_ignored: got %b want 1100", {done0, gt0, eq0, lt0});
                end
            end
        end
    endtask

    task automatic test_reset_mid_op;
        int seen0;
        seen0 = 0;
        @(negedge clk);
        a_in = 4'd3; b_in = 4'd12; sm = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done0) seen0++;
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                rst = 1'b0;
                tests_run++;
                if ({busy1, done1, gt1, eq1, lt1, busy0, done0, gt0, eq0, lt0} !== 10'b0) begin
                    tests_failed++;
                    $display("FAIL reset_mid_op_outputs: got %b want 0000000000",
                             {busy1, done1, gt1, eq1, lt1, busy0, done0, gt0, eq0, lt0});
                end
            end
        end
        tests_run++;
        if (seen0 != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_op_no_done: got %0d done cycles want 0", seen0);
        end
        check_pair("after_reset_3_12", 4'd3, 4'd12, 1'b0, 2, 3'b001, 5, 3'b001);
    endtask

    task automatic test_exhaustive;
        int l1, n1, l0, n0, xl1, xl0;
        logic [2:0] f1, f0, xf1, xf0;
        logic [3:0] ta, tb;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int is = 0; is < 2; is++) begin
                    ta = 4'(ia); tb = 4'(ib);
                    model(ta, tb, is[0], 1'b1, xf1, xl1);
                    model(ta, tb, is[0], 1'b0, xf0, xl0);
                    do_compare(ta, tb, is[0], l1, n1, f1, l0, n0, f0);
                    tests_run++;
                    if (f1 !== xf1 || l1 != xl1 || n1 != 1) begin
                        tests_failed++;
                        $display("FAIL exh_ee1 a=%0d b=%0d s=%0d: got flags=%b lat=%0d dones=%0d want flags=%b lat=%0d dones=1",
                                 ia, ib, is, f1, l1, n1, xf1, xl1);
                    end
                    tests_run++;
                    if (f0 !== xf0 || l0 != xl0 || n0 != 1) begin
                        tests_failed++;
                        $display("FAIL exh_ee0 a=%0d b=%0d s=%0d: got flags=%b lat=%0d dones=%0d want flags=%b lat=%0d dones=1",
                                 ia, ib, is, f0, l0, n0, xf0, xl0);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_equal;
        test_start_during_run;
        test_back_to_back;
        test_reset_mid_op;
        test_exhaustive;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_compare.md
SERIAL_COMPARE -- requirements
Module: serial_compare

Interface
REQ-001 SHALL have parameter WIDTH, default 8; operand width in bits, legal range 2..32.
REQ-002 SHALL have parameter EARLY_EXIT, default 1; 1 = finish at first differing bit, 0 = always examine all WIDTH bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request a comparison; sampled only in IDLE or DONE.
REQ-006 SHALL have port a  input  WIDTH  first operand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  second operand; sampled with start.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have ports gt, eq, lt  output  1 each  registered result flags (a>b, a==b, a<b).

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE with start=1, SHALL on that edge:
  - latch a, b and signed_mode;
  - set bit index to WIDTH-1;
  - enter RUN.
REQ-014 In RUN, SHALL compare exactly one latched bit pair per cycle, MSB first, with the index decrementing by 1 per cycle.
REQ-015 At index WIDTH-1 with signed_mode=1 and differing bits, SHALL invert the decision: the operand with MSB 0 is greater.
REQ-016 On the first differing bit with EARLY_EXIT=1, SHALL on that edge:
  - set gt or lt accordingly, clear eq;
  - enter DONE.
REQ-017 On index 0 with no difference found, SHALL set eq=1, clear gt and lt, and enter DONE.
REQ-018 With EARLY_EXIT=0, SHALL record the first differing bit's decision but remain in RUN until index 0 has been examined.
REQ-019 Latency SHALL be:
  - done=1 exactly N+1 cycles after the start edge, where N = bits examined (1..WIDTH);
  - with EARLY_EXIT=0, N is always WIDTH.
REQ-020 SHALL assert done for exactly one cycle in DONE, with busy=0; DONE SHALL return to IDLE unless start=1.
REQ-021 Exactly one of gt/eq/lt SHALL be high after the first done, and the flags SHALL hold until the next done.
REQ-022 start while in RUN SHALL be ignored; operands and results SHALL be unaffected.
REQ-023 start in DONE SHALL begin a new comparison the same edge (back-to-back), and done SHALL still pulse for that cycle.
REQ-024 Changes on a, b or signed_mode outside the start sampling edge SHALL NOT affect an ongoing comparison.

Reset
REQ-025 rst=1 SHALL, on the next clk edge, force IDLE and clear busy, done, gt, eq, lt, the index and the latched operands.
REQ-026 rst SHALL take priority over start and over any RUN or DONE activity.
REQ-027 Reset mid-comparison SHALL abandon it without a done pulse.

Structure
REQ-028 SHALL place the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the index-width constant derivation in shared package serial_compare_pkg.
REQ-029 SHALL use one combinational sub-module, serial_compare_cell:
  - inputs: a_bit, b_bit, invert;
  - outputs: differ, a_greater.
REQ-030 RTL SHALL be 120-400 lines and synthesizable, with no latches.

Verification (WIDTH=4 unless stated)
REQ-031 Unsigned, a=4'd9, b=4'd5, EARLY_EXIT=1: done 2 cycles after start; gt=1, eq=0, lt=0.
REQ-032 Signed, a=4'b1001 (-7), b=4'd5: done 2 cycles after start; lt=1. Same operands unsigned: gt=1.
REQ-033 a=b=4'd10: done 5 cycles after start with eq=1. With EARLY_EXIT=0, a=9, b=5 also gives done at 5 cycles with gt=1.
REQ-034 Robustness sequence:
  - start=1 held during RUN with new operands 0/15: ignored, first result unchanged;
  - start asserted during DONE: second done follows with correct result.
REQ-035 Reset mid-op: rst pulsed at cycle 2 of a=3, b=12 compare: no done; all outputs 0 on the next cycle; a subsequent compare is correct.
REQ-036 Exhaustive check of all 256 (a,b) pairs x both modes x both EARLY_EXIT values against a behavioural model, covering flags, done timing and one-hot results.
